// File: rtl/lsu_lcd_ctrl.sv
// lsu_lcd_ctrl: memory-mapped character LCD buffer and registers driving an HD44780 bus through a refresh sequencer
module lsu_lcd_ctrl #(
  parameter int DEPTH_BYTES = 32,
  parameter int LINE_BYTES = 16,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int GAP_CYC = 5,
  localparam int AW = $clog2(DEPTH_BYTES)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        st_en_i,
  input  logic [2:0]  datamode_i,
  input  logic [AW:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic [7:0]  lcd_data_o,
  output logic        busy_o
);
  localparam int LINES = DEPTH_BYTES / LINE_BYTES;
  localparam int LW = LINES > 1 ? $clog2(LINES) : 1;
  localparam int CLW = $clog2(LINE_BYTES + 1);
  localparam int MAXC = SETUP_CYC > PULSE_CYC ? (SETUP_CYC > GAP_CYC ? SETUP_CYC : GAP_CYC)
                                              : (PULSE_CYC > GAP_CYC ? PULSE_CYC : GAP_CYC);
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] line_q, line_d;
  logic [CLW-1:0] col_q, col_d;
  logic frame_q, frame_d, auto_q, auto_d, dropped_q, dropped_d, pend_v_q, pend_v_d, rs_q, rs_d;
  logic [7:0] pend_q, pend_d, dat_q, dat_d;
  logic [7:0] mem_q [DEPTH_BYTES];
  logic [7:0] mem_d [DEPTH_BYTES];
  logic [AW-1:0] a, chr_addr;
  logic [2:0] nb;
  logic ctrl_wr, cmd_wr, take, start, last, more_chr;
  function automatic logic [7:0] line_cmd(input logic [1:0] n);
    return 8'h80 | ((n[0] ? 8'h40 : 8'h00) + (n[1] ? 8'(LINE_BYTES) : 8'h00));
  endfunction
  assign a = addr_i[AW-1:0];
  assign ctrl_wr = st_en_i && addr_i[AW] && addr_i[3:2] == 2'd0;
  assign cmd_wr = st_en_i && addr_i[AW] && addr_i[3:2] == 2'd1;
  assign nb = datamode_i == 3'd0 ? 3'd1 : datamode_i == 3'd1 ? 3'd2 : 3'd4;
  assign auto_d = ctrl_wr ? data_i[1] : auto_q;
  assign take = state_q == IDLE && (pend_v_q || cmd_wr);
  assign start = (ctrl_wr && data_i[0]) || auto_d;
  assign chr_addr = AW'(int'(line_q) * LINE_BYTES + int'(col_q));
  assign more_chr = col_q != CLW'(LINE_BYTES);
  assign last = !more_chr && line_q == LW'(LINES - 1);
  assign busy_o = state_q != IDLE;
  assign lcd_en_o = state_q == PULSE;
  assign lcd_rs_o = rs_q;
  assign lcd_data_o = dat_q;
  assign lcd_rw_o = 1'b0;
  assign data_o = addr_i[AW] ? (addr_i[3:2] == 2'd0 ? {30'b0, auto_q, 1'b0} :
                                addr_i[3:2] == 2'd2 ? {29'b0, dropped_q, pend_v_q, busy_o} : 32'd0)
                             : {mem_q[a + AW'(3)], mem_q[a + AW'(2)], mem_q[a + AW'(1)], mem_q[a]};
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < 4; k++)
      if (st_en_i && !addr_i[AW] && 3'(k) < nb) mem_d[a + AW'(k)] = data_i[8*k +: 8];
  end
  always_comb begin
    dropped_d = ctrl_wr && data_i[2] ? 1'b0 : dropped_q;
    pend_v_d = take ? 1'b0 : pend_v_q;
    pend_d = pend_q;
    if (cmd_wr) begin
      if (pend_v_q && !take) dropped_d = 1'b1;
      else begin
        pend_d = data_i[7:0];
        pend_v_d = pend_v_q || !take;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    line_d = line_q;
    col_d = col_q;
    frame_d = frame_q;
    rs_d = rs_q;
    dat_d = dat_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = SETUP;
          cnt_d = CW'(SETUP_CYC - 1);
          frame_d = 1'b0;
          rs_d = 1'b0;
          dat_d = pend_v_q ? pend_q : data_i[7:0];
        end else if (start) begin
          state_d = SETUP;
          cnt_d = CW'(SETUP_CYC - 1);
          frame_d = 1'b1;
          line_d = '0;
          col_d = '0;
          rs_d = 1'b0;
          dat_d = line_cmd(2'b00);
        end
      end
      SETUP: begin
        state_d = cnt_q == '0 ? PULSE : SETUP;
        cnt_d = cnt_q == '0 ? CW'(PULSE_CYC - 1) : cnt_q - CW'(1);
      end
      PULSE: begin
        state_d = cnt_q == '0 ? GAP : PULSE;
        cnt_d = cnt_q == '0 ? CW'(GAP_CYC - 1) : cnt_q - CW'(1);
      end
      default: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else if (!frame_q || last) state_d = IDLE;
        else begin
          state_d = SETUP;
          cnt_d = CW'(SETUP_CYC - 1);
          rs_d = more_chr;
          dat_d = more_chr ? mem_q[chr_addr] : line_cmd(2'(line_q + LW'(1)));
          line_d = more_chr ? line_q : line_q + LW'(1);
          col_d = more_chr ? col_q + CLW'(1) : '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      line_q <= '0;
      col_q <= '0;
      frame_q <= 1'b0;
      auto_q <= 1'b0;
      dropped_q <= 1'b0;
      pend_v_q <= 1'b0;
      pend_q <= '0;
      rs_q <= 1'b0;
      dat_q <= '0;
      mem_q <= '{default: 8'h20};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      line_q <= line_d;
      col_q <= col_d;
      frame_q <= frame_d;
      auto_q <= auto_d;
      dropped_q <= dropped_d;
      pend_v_q <= pend_v_d;
      pend_q <= pend_d;
      rs_q <= rs_d;
      dat_q <= dat_d;
      mem_q <= mem_d;
    end
  end
endmodule
